// File: rtl/sva_thread_sched.sv
// Thread-pool scheduler: each tick steps every live thread through one shared evaluator, launches a fresh attempt, compacts survivors.
// Requests hold stable until ev_ready; round_done follows the fresh attempt's response by two cycles; ticks seen while busy are dropped.
module sva_thread_sched #(
  parameter int          SLOTS       = 4,
  parameter int          STATE_W     = 4,
  parameter int          TIMER_W     = 8,
  parameter int unsigned START_STATE = 0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       tick,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [STATE_W-1:0]         ev_state,
  output logic [TIMER_W-1:0]         ev_start,
  input  logic                       rsp_valid,
  input  logic                       rsp_active,
  input  logic [STATE_W-1:0]         rsp_state,
  output logic                       busy,
  output logic                       round_done,
  output logic [$clog2(SLOTS+1)-1:0] live_cnt,
  output logic                       overflow,
  output logic                       ovf_sticky,
  output logic                       missed_tick,
  output logic [TIMER_W-1:0]         period
);

  localparam int CW = $clog2(SLOTS + 1);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, NREQ, NWAIT, DONE} state_t;

  state_t               state_q;
  logic [STATE_W-1:0]   slot_st_q [SLOTS];
  logic [TIMER_W-1:0]   slot_sp_q [SLOTS];
  logic [CW-1:0]        n_q, rd_q, wr_q, live_q;
  logic [TIMER_W-1:0]   stamp_q, period_q;
  logic                 ev_valid_q, busy_q, done_q, ovf_q, ovf_sticky_q, missed_q;
  logic [STATE_W-1:0]   ev_state_q;
  logic [TIMER_W-1:0]   ev_start_q;

  logic [CW-1:0]        rd_d;
  logic                 rsp_take, room, surv, drop;
  logic [TIMER_W-1:0]   wr_sp_d;

  assign rd_d     = rd_q + CW'(1);
  assign rsp_take = rsp_valid && (state_q == WAIT || state_q == NWAIT);
  assign room     = (wr_q != CW'(SLOTS));
  assign surv     = rsp_take && rsp_active && room;
  assign drop     = rsp_take && rsp_active && !room;
  // A stepped thread keeps its original stamp; the fresh attempt takes the round's stamp.
  assign wr_sp_d  = (state_q == WAIT) ? slot_sp_q[rd_q[IW-1:0]] : stamp_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      live_q       <= '0;
      stamp_q      <= '0;
      period_q     <= '0;
      ev_valid_q   <= 1'b0;
      ev_state_q   <= '0;
      ev_start_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      ovf_q    <= drop;
      missed_q <= tick && (state_q != IDLE);
      if (drop) ovf_sticky_q <= 1'b1;
      if (tick) period_q <= period_q + TIMER_W'(1);
      if (surv) begin
        slot_st_q[wr_q[IW-1:0]] <= rsp_state;
        slot_sp_q[wr_q[IW-1:0]] <= wr_sp_d;
        wr_q                    <= wr_q + CW'(1);
      end
      case (state_q)
        IDLE: if (tick) begin
          n_q        <= live_q;
          rd_q       <= '0;
          wr_q       <= '0;
          stamp_q    <= period_q;
          busy_q     <= 1'b1;
          ev_valid_q <= 1'b1;
          if (live_q != '0) begin
            state_q    <= REQ;
            ev_state_q <= slot_st_q[0];
            ev_start_q <= slot_sp_q[0];
          end else begin
            state_q    <= NREQ;
            ev_state_q <= STATE_W'(START_STATE);
            ev_start_q <= period_q;
          end
        end
        REQ, NREQ: if (ev_ready) begin
          ev_valid_q <= 1'b0;
          ev_state_q <= '0;
          ev_start_q <= '0;
          state_q    <= (state_q == REQ) ? WAIT : NWAIT;
        end
        WAIT: if (rsp_valid) begin
          rd_q       <= rd_d;
          ev_valid_q <= 1'b1;
          // Next unread slot is strictly above wr_q, so this read never sees a same-cycle write.
          if (rd_d < n_q) begin
            state_q    <= REQ;
            ev_state_q <= slot_st_q[rd_d[IW-1:0]];
            ev_start_q <= slot_sp_q[rd_d[IW-1:0]];
          end else begin
            state_q    <= NREQ;
            ev_state_q <= STATE_W'(START_STATE);
            ev_start_q <= stamp_q;
          end
        end
        NWAIT: if (rsp_valid) state_q <= DONE;
        DONE: begin
          live_q  <= wr_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ev_valid    = ev_valid_q;
  assign ev_state    = ev_state_q;
  assign ev_start    = ev_start_q;
  assign busy        = busy_q;
  assign round_done  = done_q;
  assign live_cnt    = live_q;
  assign overflow    = ovf_q;
  assign ovf_sticky  = ovf_sticky_q;
  assign missed_tick = missed_q;
  assign period      = period_q;

endmodule

// File: tb/tb_sva_thread_sched.sv
// Scoreboard bench for sva_thread_sched: a pool model predicts every evaluator request and round outcome.
module tb_sva_thread_sched;
  localparam int SLOTS = 4;
  localparam int SW    = 4;
  localparam int TW    = 2;
  localparam int CW    = $clog2(SLOTS + 1);

  logic          sys_clk = 1'b0;
  logic          sys_rst, tick, ev_ready, rsp_valid, rsp_active;
  logic [SW-1:0] rsp_state;
  logic          ev_valid, busy, round_done, overflow, ovf_sticky, missed_tick;
  logic [SW-1:0] ev_state;
  logic [TW-1:0] ev_start, period;
  logic [CW-1:0] live_cnt;

  sva_thread_sched #(.SLOTS(SLOTS), .STATE_W(SW), .TIMER_W(TW), .START_STATE(0)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_state(ev_state), .ev_start(ev_start),
    .rsp_valid(rsp_valid), .rsp_active(rsp_active), .rsp_state(rsp_state),
    .busy(busy), .round_done(round_done), .live_cnt(live_cnt),
    .overflow(overflow), .ovf_sticky(ovf_sticky), .missed_tick(missed_tick), .period(period)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {logic [SW-1:0] st; logic [TW-1:0] sp;} req_t;

  req_t          exp_q[$];
  logic [SW-1:0] m_st[$];
  logic [TW-1:0] m_sp[$];
  logic [TW-1:0] m_period;
  bit            m_ovf;
  bit            act_t[5];
  logic [SW-1:0] nxt_t[5];
  int            n_checks = 0, n_fail = 0;
  int            cyc = 0, ovf_cnt = 0, miss_cnt = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) begin
    if (overflow)    ovf_cnt  <= ovf_cnt + 1;
    if (missed_tick) miss_cnt <= miss_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_round(input int stall_k, input int stall_n, input int miss_k);
    int            n, cnt, c0, extra;
    bit            drop;
    req_t          e;
    logic [SW-1:0] nst[$];
    logic [TW-1:0] nsp[$];
    logic [TW-1:0] fresh_sp;
    n        = m_st.size();
    extra    = 0;
    fresh_sp = m_period;
    for (int i = 0; i < n; i++) exp_q.push_back('{st: m_st[i], sp: m_sp[i]});
    exp_q.push_back('{st: SW'(0), sp: fresh_sp});
    @(negedge sys_clk);
    tick = 1'b1;
    c0 = cyc;
    @(negedge sys_clk);
    tick = 1'b0;
    m_period = m_period + TW'(1);
    check_eq("busy_up", 32'(busy), 32'd1);
    check_eq("vld_t1", 32'(ev_valid), 32'd1);
    for (int k = 0; k <= n; k++) begin
      cnt = 0;
      while (!ev_valid && cnt < 50) begin @(negedge sys_clk); cnt++; end
      check_eq("req_seen", 32'(ev_valid), 32'd1);
      e = exp_q.pop_front();
      check_eq("ev_state", 32'(ev_state), 32'(e.st));
      check_eq("ev_start", 32'(ev_start), 32'(e.sp));
      if (k == stall_k) begin
        extra += stall_n;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge sys_clk);
          check_eq("stall_vld", 32'(ev_valid), 32'd1);
          check_eq("stall_state", 32'(ev_state), 32'(e.st));
          check_eq("stall_start", 32'(ev_start), 32'(e.sp));
        end
      end
      ev_ready = 1'b1;
      @(negedge sys_clk);
      ev_ready = 1'b0;
      check_eq("vld_drop", 32'(ev_valid), 32'd0);
      if (k == miss_k) begin
        extra += 1;
        tick = 1'b1;
        @(negedge sys_clk);
        tick = 1'b0;
        m_period = m_period + TW'(1);
        check_eq("missed_tick", 32'(missed_tick), 32'd1);
        check_eq("miss_period", 32'(period), 32'(m_period));
      end
      rsp_valid  = 1'b1;
      rsp_active = act_t[k];
      rsp_state  = nxt_t[k];
      drop = 1'b0;
      if (act_t[k]) begin
        if (nst.size() < SLOTS) begin
          nst.push_back(nxt_t[k]);
          nsp.push_back((k < n) ? m_sp[k] : fresh_sp);
        end else drop = 1'b1;
      end
      @(negedge sys_clk);
      rsp_valid  = 1'b0;
      rsp_active = 1'b0;
      check_eq("overflow", 32'(overflow), 32'(drop));
      if (drop) m_ovf = 1'b1;
    end
    cnt = 0;
    while (!round_done && cnt < 50) begin @(negedge sys_clk); cnt++; end
    check_eq("round_done", 32'(round_done), 32'd1);
    check_eq("round_len", 32'(cyc - c0), 32'(2 * (n + 1) + 2 + extra));
    check_eq("live_cnt", 32'(live_cnt), 32'(nst.size()));
    check_eq("busy_down", 32'(busy), 32'd0);
    check_eq("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
    check_eq("period", 32'(period), 32'(m_period));
    m_st = nst;
    m_sp = nsp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; tick = 1'b0; ev_ready = 1'b0;
    rsp_valid = 1'b0; rsp_active = 1'b0; rsp_state = '0;
    m_period = '0; m_ovf = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_vld", 32'(ev_valid), 32'd0);
    check_eq("rst_live", 32'(live_cnt), 32'd0);
    check_eq("rst_done", 32'(round_done), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_sticky", 32'(ovf_sticky), 32'd0);
    check_eq("rst_miss", 32'(missed_tick), 32'd0);
    check_eq("rst_period", 32'(period), 32'd0);
    check_eq("rst_evst", 32'({ev_state, ev_start}), 32'd0);

    act_t = '{1, 0, 0, 0, 0}; nxt_t = '{3, 0, 0, 0, 0};
    do_round(-1, 0, -1);
    act_t = '{1, 1, 0, 0, 0}; nxt_t = '{1, 2, 0, 0, 0};
    do_round(-1, 0, -1);
    act_t = '{1, 1, 1, 0, 0}; nxt_t = '{1, 2, 3, 0, 0};
    do_round(-1, 0, -1);

    @(negedge sys_clk);
    rsp_valid = 1'b1; rsp_active = 1'b1; rsp_state = 4'hF;
    @(negedge sys_clk);
    rsp_valid = 1'b0; rsp_active = 1'b0;
    @(negedge sys_clk);
    check_eq("idle_rsp_live", 32'(live_cnt), 32'd3);
    check_eq("idle_rsp_busy", 32'(busy), 32'd0);

    act_t = '{1, 0, 1, 1, 0}; nxt_t = '{5, 6, 7, 8, 0};
    do_round(1, 5, -1);
    act_t = '{1, 1, 1, 1, 0}; nxt_t = '{9, 10, 11, 12, 0};
    do_round(-1, 0, -1);
    act_t = '{1, 1, 1, 1, 1}; nxt_t = '{1, 2, 3, 4, 5};
    do_round(-1, 0, -1);
    act_t = '{0, 1, 0, 1, 0}; nxt_t = '{6, 7, 8, 9, 10};
    do_round(-1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check_eq("no_second_round", 32'({busy, ev_valid}), 32'd0);
    end

    @(negedge sys_clk);
    tick = 1'b1;
    @(negedge sys_clk);
    tick = 1'b0; ev_ready = 1'b1;
    @(negedge sys_clk);
    ev_ready = 1'b0; sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_live", 32'(live_cnt), 32'd0);
    check_eq("mid_rst_vld", 32'(ev_valid), 32'd0);
    check_eq("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    check_eq("mid_rst_period", 32'(period), 32'd0);
    m_st.delete(); m_sp.delete(); m_period = '0; m_ovf = 1'b0;

    act_t = '{1, 0, 0, 0, 0}; nxt_t = '{4, 0, 0, 0, 0};
    do_round(-1, 0, -1);
    act_t = '{1, 0, 0, 0, 0}; nxt_t = '{2, 3, 0, 0, 0};
    do_round(-1, 0, -1);

    check_eq("ovf_pulses", 32'(ovf_cnt), 32'd1);
    check_eq("miss_pulses", 32'(miss_cnt), 32'd1);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
